// File: rtl/ahb_master_req_ctrl.sv
// AHB master-side request controller: takes one burst command, requests the
// bus, then walks the address phase beat by beat until the last beat is accepted.

package AHB_package;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } burst_type;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

module ahb_master_req_ctrl
    import AHB_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  burst_type             cmd_burst,
    input  logic                  cmd_write,
    input  logic [3:0]            cmd_len,
    output logic                  hreq,
    input  logic                  hgrant,
    input  logic                  hwait,
    output logic [1:0]            htrans,
    output logic [ADDR_WIDTH-1:0] haddr,
    output burst_type             hburst,
    output logic                  hwrite,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BEAT_BYTES);

    state_t                state;
    logic [3:0]            cnt;
    logic [3:0]            limit;
    logic                  acc;
    logic                  is_wrap;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Last beat index for a burst; the same count the arbiter's burst monitor uses.
    function automatic logic [3:0] burst_limit(input burst_type b, input logic [3:0] len);
        logic [3:0] l;
        case (b)
            SINGLE:        l = 4'd0;
            INCR:          l = len;
            WRAP4, INCR4:  l = 4'd3;
            WRAP8, INCR8:  l = 4'd7;
            default:       l = 4'd15;
        endcase
        return l;
    endfunction

    // Beat acceptance and next-beat address (linear or wrapping within the span).
    always_comb begin
        acc       = hgrant & ~hwait;
        is_wrap   = hburst inside {WRAP4, WRAP8, WRAP16};
        incr_addr = haddr + BEAT_STEP;
        wrap_mask = ADDR_WIDTH'((32'(limit) + 32'd1) * BEAT_BYTES - 32'd1);
        next_addr = is_wrap ? ((haddr & ~wrap_mask) | (incr_addr & wrap_mask))
                            : incr_addr;
    end

    // Request/transfer FSM with all outputs registered.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            limit     <= '0;
            cmd_ready <= 1'b1;
            hreq      <= 1'b0;
            htrans    <= HTRANS_IDLE;
            haddr     <= '0;
            hburst    <= SINGLE;
            hwrite    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        haddr     <= cmd_addr;
                        hburst    <= cmd_burst;
                        hwrite    <= cmd_write;
                        limit     <= burst_limit(cmd_burst, cmd_len);
                        cnt       <= '0;
                        hreq      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (hgrant) begin
                        htrans <= HTRANS_NONSEQ;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (acc) begin
                        if (cnt == limit) begin
                            done      <= 1'b1;
                            hreq      <= 1'b0;
                            htrans    <= HTRANS_IDLE;
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            cnt    <= cnt + 4'd1;
                            haddr  <= next_addr;
                            htrans <= HTRANS_SEQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
